icache_direct: RTL
==================

ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 SHALL have parameter LINE_COUNT, default 16: number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter BLOCK_WORDS, default 4: 32-bit words per line (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port is_input_valid  input  1  CPU fetch request present.
REQ-006 SHALL have port addr  input  32  byte address of the requested instruction; bits [1:0] ignored.
REQ-007 SHALL have port is_ready  output  1  cache can accept a request or flush this cycle.
REQ-008 SHALL have port is_output_valid  output  1  dout valid this cycle (one-cycle pulse).
REQ-009 SHALL have port dout  output  32  fetched instruction word.
REQ-010 SHALL have port is_hit  output  1  qualifies is_output_valid: 1 when the lookup hit without refill.
REQ-011 SHALL have port flush  input  1  invalidate all lines.
REQ-012 SHALL have port mem_req  output  1  block refill request to backing memory.
REQ-013 SHALL have port mem_addr  output  32  block-aligned refill address.
REQ-014 SHALL have port mem_rdata_valid  input  1  refill data present this cycle.
REQ-015 SHALL have port mem_rdata  input  32*BLOCK_WORDS  full block, word 0 in the least-significant bits.

Function
REQ-016 SHALL split addr into word offset [log2(BLOCK_WORDS)+1:2], index (next log2(LINE_COUNT) bits) and tag (remaining upper bits); defaults: offset [3:2], index [7:4], tag [31:8].
REQ-017 SHALL implement FSM IDLE, COMPARE, ALLOCATE; is_ready = 1 only in IDLE.
REQ-018 In IDLE, flush=1 SHALL clear every valid bit in that cycle and stay in IDLE; flush takes priority over a simultaneous request, which is dropped.
REQ-019 In IDLE with is_input_valid=1 and flush=0, the cache SHALL latch addr and move to COMPARE.
REQ-020 In COMPARE, hit (valid and tag match) SHALL drive is_output_valid=1, is_hit=1, dout = selected word for exactly one cycle and return to IDLE (hit latency: 1 cycle after accept).
REQ-021 In COMPARE, miss SHALL move to ALLOCATE and assert mem_req with mem_addr = latched addr with offset and byte bits zeroed.
REQ-022 In ALLOCATE, mem_req and mem_addr SHALL hold stable until mem_rdata_valid=1; memory latency is arbitrary (>=1 cycle).
REQ-023 On mem_rdata_valid in ALLOCATE, the cache SHALL write the block, tag and valid bit of the indexed line, deassert mem_req the next cycle and return to COMPARE.
REQ-024 The post-refill COMPARE SHALL output the word with is_output_valid=1 and is_hit=0 (miss latency = memory latency + 2 cycles).
REQ-025 mem_rdata_valid outside ALLOCATE SHALL be ignored.
REQ-026 flush and is_input_valid outside IDLE SHALL be ignored.
REQ-027 A refill SHALL overwrite the indexed line unconditionally; no write-back path exists (read-only cache).

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, clear all valid bits, and drive is_output_valid=0, is_hit=0, dout=0, mem_req=0, mem_addr=0.
REQ-029 Reset during ALLOCATE SHALL abandon the refill; a late mem_rdata_valid after release SHALL be ignored per REQ-025.
REQ-030 Data and tag arrays need not be cleared by reset.

Configuration
REQ-031 Macro ICACHE_STATS_EN defined: SHALL add outputs hit_count and miss_count (32 bits each), incremented on each hit COMPARE and each miss COMPARE, cleared by reset, saturating at all-ones; not cleared by flush.
REQ-032 Macro ICACHE_STATS_EN undefined: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-033 Package icache_pkg SHALL hold the FSM state enum and default LINE_COUNT/BLOCK_WORDS constants.
REQ-034 Sub-module icache_line_array SHALL hold tag, valid and data storage with an asynchronous read port and one synchronous write port plus a flush-all input.

Verification
REQ-035 Reset, request addr=0x0000_0010, memory returns block {0x4,0x3,0x2,0x1} after 3 cycles -> mem_addr=0x0000_0010, then dout=0x1, is_hit=0.
REQ-036 Same addr again, then addr=0x0000_001C -> each hit, 1 cycle after accept, dout=0x1 then 0x4, is_hit=1, mem_req stays 0.
REQ-037 Request addr=0x0000_0110 (same index 1, new tag) -> miss, mem_addr=0x0000_0110, line replaced; re-request 0x10 -> miss again.
REQ-038 flush with simultaneous request in IDLE -> request dropped, next request to 0x10 misses.
REQ-039 reset_n low during ALLOCATE, mem_rdata_valid after release -> mem_req=0, state IDLE, no line written.
REQ-040 With ICACHE_STATS_EN: sequence of 3 hits, 2 misses -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// The optional statistics counters are enabled with the ICACHE_STATS_EN macro.
package icache_pkg;

    localparam int unsigned DEFAULT_LINE_COUNT  = 16;
    localparam int unsigned DEFAULT_BLOCK_WORDS = 4;
    localparam int unsigned WORD_BITS           = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPARE  = 2'd1,
        ST_ALLOCATE = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Tag, valid and block storage for the instruction cache: combinational read,
// one synchronous write port and a single-cycle invalidate-all.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned LINE_COUNT = DEFAULT_LINE_COUNT,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned TAG_W      = 24,
    parameter int unsigned BLOCK_BITS = 128
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [BLOCK_BITS-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [BLOCK_BITS-1:0] i_wr_data,
    input  logic                  i_flush_all
);

    logic [LINE_COUNT-1:0] w_valid;
    logic [TAG_W-1:0]      r_tag_mem  [LINE_COUNT];
    logic [BLOCK_BITS-1:0] r_data_mem [LINE_COUNT];

    // One valid flop per line so invalidate-all costs a single cycle.
    genvar gi;
    for (gi = 0; gi < LINE_COUNT; gi++) begin : g_valid
        logic r_valid;

        always_ff @(posedge clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_valid <= 1'b0;
            end else if (i_flush_all) begin
                r_valid <= 1'b0;
            end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
                r_valid <= 1'b1;
            end
        end

        assign w_valid[gi] = r_valid;
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_idx]  <= i_wr_tag;
            r_data_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = w_valid[i_rd_idx];
    assign o_rd_tag   = r_tag_mem[i_rd_idx];
    assign o_rd_data  = r_data_mem[i_rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with single-block refill from memory.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_direct
    import icache_pkg::*;
#(
    parameter int unsigned LINE_COUNT  = DEFAULT_LINE_COUNT,
    parameter int unsigned BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            is_input_valid,
    input  logic [31:0]                     addr,
    output logic                            is_ready,
    output logic                            is_output_valid,
    output logic [31:0]                     dout,
    output logic                            is_hit,
    input  logic                            flush,
    output logic                            mem_req,
    output logic [31:0]                     mem_addr,
    input  logic                            mem_rdata_valid,
    input  logic [WORD_BITS*BLOCK_WORDS-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
`endif
);

    localparam int unsigned OFF_W      = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W      = $clog2(LINE_COUNT);
    localparam int unsigned IDX_LSB    = OFF_W + 2;
    localparam int unsigned TAG_LSB    = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W      = 32 - TAG_LSB;
    localparam int unsigned BLOCK_BITS = WORD_BITS * BLOCK_WORDS;

    icache_state_e         r_state;
    icache_state_e         w_state_next;
    logic [31:2]           r_addr;
    logic                  r_mem_req;
    logic [31:0]           r_mem_addr;
    logic                  r_refilled;

    logic [OFF_W-1:0]      w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_line_valid;
    logic [TAG_W-1:0]      w_line_tag;
    logic [BLOCK_BITS-1:0] w_line_data;
    logic [31:0]           w_words [BLOCK_WORDS];
    logic [31:0]           w_word;
    logic                  w_lookup_hit;
    logic                  w_accept;
    logic                  w_flush;
    logic                  w_fill;
    logic                  w_start_miss;
    logic                  w_out_valid;
    logic                  w_unused_byte;

    // Instructions are word aligned; the byte lane bits carry no information.
    assign w_unused_byte = ^addr[1:0];

    assign w_off = r_addr[IDX_LSB-1:2];
    assign w_idx = r_addr[TAG_LSB-1:IDX_LSB];
    assign w_tag = r_addr[31:TAG_LSB];

    icache_line_array #(
        .LINE_COUNT (LINE_COUNT),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_lines (
        .clk         (clk),
        .i_reset_n   (reset_n),
        .i_rd_idx    (w_idx),
        .o_rd_valid  (w_line_valid),
        .o_rd_tag    (w_line_tag),
        .o_rd_data   (w_line_data),
        .i_wr_en     (w_fill),
        .i_wr_idx    (w_idx),
        .i_wr_tag    (w_tag),
        .i_wr_data   (mem_rdata),
        .i_flush_all (w_flush)
    );

    genvar gi;
    for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
        assign w_words[gi] = w_line_data[gi*WORD_BITS +: WORD_BITS];
    end

    assign w_word       = w_words[w_off];
    assign w_lookup_hit = w_line_valid && (w_line_tag == w_tag);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_flush      = 1'b0;
        w_fill       = 1'b0;
        w_start_miss = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A flush in the same cycle as a request wins; the request is lost.
                if (flush) begin
                    w_flush = 1'b1;
                end else if (is_input_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_lookup_hit) begin
                    w_out_valid  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_start_miss = 1'b1;
                    w_state_next = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                if (mem_rdata_valid) begin
                    w_fill       = 1'b1;
                    w_state_next = ST_COMPARE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_refilled <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr <= addr[31:2];
            end
            if (w_start_miss) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {r_addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
            end else if (w_fill) begin
                r_mem_req <= 1'b0;
            end
            // Marks the COMPARE that follows a refill so it reports is_hit=0.
            if (w_accept) begin
                r_refilled <= 1'b0;
            end else if (w_fill) begin
                r_refilled <= 1'b1;
            end
        end
    end

    always_comb begin
        is_ready        = (r_state == ST_IDLE);
        is_output_valid = w_out_valid;
        is_hit          = w_out_valid && !r_refilled;
        dout            = w_out_valid ? w_word : '0;
        mem_req         = r_mem_req;
        mem_addr        = r_mem_addr;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_out_valid && !r_refilled && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
